// File: rtl/imem_refill_ctrl.sv
// Instruction-memory refill controller: returns one cache line MEM_LATENCY cycles after a request
// is accepted, holds it until ack or withdrawal, and counts accepted refills (saturating).
module imem_refill_ctrl #(
  parameter int LINE_WIDTH  = 128,
  parameter int LADDR_WIDTH = 28,
  parameter int DEPTH_LOG2  = 10,
  parameter int MEM_LATENCY = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req,
  input  logic [LADDR_WIDTH-1:0] req_addr,
  input  logic                   data_filled_ack,
  input  logic                   load_en,
  input  logic [DEPTH_LOG2-1:0]  load_addr,
  input  logic [LINE_WIDTH-1:0]  load_data,
  output logic                   mem_data_rdy,
  output logic [LINE_WIDTH-1:0]  data_to_fill,
  output logic                   busy,
  output logic [15:0]            refill_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [7:0] LAT_M1 = 8'(MEM_LATENCY - 1);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [LINE_WIDTH-1:0]   data_q, data_d;
  logic [15:0]             refill_cnt_q, refill_cnt_d;

  logic [LINE_WIDTH-1:0]   mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [LINE_WIDTH-1:0]   rd_line;
  logic                    unused_addr_bits;

  // Upper line-address bits are deliberately dropped: addresses wrap modulo the depth.
  assign unused_addr_bits = ^req_addr[LADDR_WIDTH-1:DEPTH_LOG2];

  // In IDLE the read targets the incoming request (needed when MEM_LATENCY is 1).
  assign rd_idx  = (state_q == S_IDLE) ? req_addr[DEPTH_LOG2-1:0] : idx_q;
  assign rd_line = (load_en && (load_addr == rd_idx)) ? load_data : mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    data_d       = data_q;
    refill_cnt_d = refill_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d = req_addr[DEPTH_LOG2-1:0];
          if (refill_cnt_q != 16'hFFFF) begin
            refill_cnt_d = refill_cnt_q + 16'd1;
          end
          if (MEM_LATENCY == 1) begin
            data_d  = rd_line;
            state_d = S_RESP;
          end else begin
            cnt_d   = LAT_M1;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          data_d  = rd_line;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP: begin
        if (data_filled_ack || !req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      idx_q        <= '0;
      data_q       <= '0;
      refill_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      refill_cnt_q <= refill_cnt_d;
    end
  end

  assign mem_data_rdy = (state_q == S_RESP);
  assign busy         = (state_q != S_IDLE);
  assign data_to_fill = data_q;
  assign refill_count = refill_cnt_q;

endmodule

// File: tb/tb_imem_refill_ctrl.sv
// Directed bench for imem_refill_ctrl: a MEM_LATENCY=5 instance plus a MEM_LATENCY=1 instance on shared inputs.
module tb_imem_refill_ctrl;

  localparam logic [127:0] LINE_A = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
  localparam logic [127:0] LINE_B = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic [27:0]  req_addr;
  logic         ack;
  logic         load_en;
  logic [9:0]   load_addr;
  logic [127:0] load_data;

  logic         rdy, busy;
  logic [127:0] data;
  logic [15:0]  cnt;
  logic         rdy1, busy1;
  logic [127:0] data1;
  logic [15:0]  cnt1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_refill_ctrl #(.LINE_WIDTH(128), .LADDR_WIDTH(28), .DEPTH_LOG2(10), .MEM_LATENCY(5)) dut (
    .clk(clk), .reset(rst_n), .req(req), .req_addr(req_addr), .data_filled_ack(ack),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .mem_data_rdy(rdy), .data_to_fill(data), .busy(busy), .refill_count(cnt)
  );

  imem_refill_ctrl #(.LINE_WIDTH(128), .LADDR_WIDTH(28), .DEPTH_LOG2(10), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(rst_n), .req(req), .req_addr(req_addr), .data_filled_ack(ack),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .mem_data_rdy(rdy1), .data_to_fill(data1), .busy(busy1), .refill_count(cnt1)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; req = 1'b0; req_addr = '0; ack = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("reset_rdy", 128'(rdy), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_data", data, 128'd0);
    chk("reset_count", 128'(cnt), 128'd0);
    rst_n = 1'b1;

    // preload
    load_en = 1'b1; load_addr = 10'd3; load_data = LINE_A; tick();
    load_addr = 10'd5; load_data = LINE_B; tick();
    load_en = 1'b0;

    // basic refill of index 3
    req = 1'b1; req_addr = 28'h3; tick();
    chk("basic_busy_k1", 128'(busy), 128'd1);
    chk("basic_rdy_k1", 128'(rdy), 128'd0);
    chk("basic_count", 128'(cnt), 128'd1);
    chk("lat1_rdy_k1", 128'(rdy1), 128'd1);
    chk("lat1_data_k1", data1, LINE_A);
    chk("lat1_busy_k1", 128'(busy1), 128'd1);
    chk("lat1_count", 128'(cnt1), 128'd1);
    repeat (4) tick();
    chk("basic_rdy_k4", 128'(rdy), 128'd0);
    chk("basic_busy_k4", 128'(busy), 128'd1);
    tick();
    chk("basic_rdy_k5", 128'(rdy), 128'd1);
    chk("basic_data_k5", data, LINE_A);
    tick();
    chk("basic_rdy_hold", 128'(rdy), 128'd1);
    ack = 1'b1; tick();
    chk("basic_rdy_ack", 128'(rdy), 128'd0);
    chk("basic_busy_ack", 128'(busy), 128'd0);
    chk("basic_count_ack", 128'(cnt), 128'd1);
    req = 1'b0; ack = 1'b0; tick();

    // withdraw during WAIT: not cancelled, one RESP cycle
    req = 1'b1; req_addr = 28'h5; tick();
    req = 1'b0;
    repeat (4) tick();
    chk("wd_rdy_k4", 128'(rdy), 128'd0);
    tick();
    chk("wd_rdy_k5", 128'(rdy), 128'd1);
    chk("wd_data_k5", data, LINE_B);
    tick();
    chk("wd_rdy_k6", 128'(rdy), 128'd0);
    chk("wd_busy_k6", 128'(busy), 128'd0);

    // address wrap; req_addr changes in WAIT are ignored
    req = 1'b1; req_addr = 28'h403; tick();
    req = 1'b0; req_addr = 28'h5;
    repeat (5) tick();
    chk("wrap_rdy", 128'(rdy), 128'd1);
    chk("wrap_data", data, LINE_A);
    tick();

    // load forwarded on the capture edge
    req = 1'b1; req_addr = 28'h3; tick();
    req = 1'b0;
    repeat (4) tick();
    load_en = 1'b1; load_addr = 10'd3; load_data = 128'h1; tick();
    load_en = 1'b0;
    chk("fwd_rdy", 128'(rdy), 128'd1);
    chk("fwd_data", data, 128'h1);
    tick();
    chk("fwd_count", 128'(cnt), 128'd4);

    // asynchronous reset mid-WAIT
    req = 1'b1; req_addr = 28'h5; tick();
    req = 1'b0; tick(); tick();
    chk("rst_busy_before", 128'(busy), 128'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rdy", 128'(rdy), 128'd0);
    chk("rst_data", data, 128'd0);
    chk("rst_count", 128'(cnt), 128'd0);
    #2 rst_n = 1'b1;
    tick();
    req = 1'b1; req_addr = 28'h5; tick();
    req = 1'b0;
    repeat (5) tick();
    chk("post_rst_rdy", 128'(rdy), 128'd1);
    chk("post_rst_data", data, LINE_B);
    chk("post_rst_count", 128'(cnt), 128'd1);
    tick();

    // back-to-back with req and ack held: rdy after k+5 and k+12
    req = 1'b1; req_addr = 28'h3; ack = 1'b1; tick();
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk($sformatf("b2b_rdy_%0d", i), 128'(rdy), ((i == 5) || (i == 12)) ? 128'd1 : 128'd0);
    end
    chk("b2b_count", 128'(cnt), 128'd4);
    req = 1'b0; ack = 1'b0;
    repeat (7) tick();
    chk("b2b_busy_end", 128'(busy), 128'd0);

    // saturation: preset the counter just below the limit
    force dut.refill_cnt_d = 16'hFFFE;
    tick();
    release dut.refill_cnt_d;
    chk("sat_preset", 128'(cnt), 128'hFFFE);
    req = 1'b1; req_addr = 28'h3; ack = 1'b1; tick();
    chk("sat_reach", 128'(cnt), 128'hFFFF);
    repeat (7) tick();
    chk("sat_busy", 128'(busy), 128'd1);
    chk("sat_hold", 128'(cnt), 128'hFFFF);
    req = 1'b0; ack = 1'b0;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
